// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite widths and bus codes, plus the interconnect's package.
// The defines are guarded so every bundle file may rely on them.
`ifndef AHB_DEFINES_SV
`define AHB_DEFINES_SV
`define w_HADDR  32
`define w_HTRANS 2
`define w_HSIZE  3
`define w_HBURST 3
`define w_HWDATA 32
`define w_HRDATA 32
`define HTRANS_IDLE   2'h0
`define HTRANS_BUSY   2'h1
`define HTRANS_NONSEQ 2'h2
`define HTRANS_SEQ    2'h3
`define HRESP_OKAY    2'h0
`define HRESP_ERROR   2'h1
`endif

package ahb_lite_interconnect_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } dflt_state_e;

   // Slot code that no slave can own (NSLV <= 15).
   localparam logic [3:0] DSEL_DFLT = 4'hF;

   // NONSEQ and SEQ both carry HTRANS[1] set.
   function automatic logic trans_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for active
// transfers, zero-wait OKAY otherwise.
module ahb_default_slave
   import ahb_lite_interconnect_pkg::*;
#(
   parameter logic [1:0] ERR_RESP = `HRESP_ERROR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hready,
   input  logic       unmapped,
   input  logic       active,
   output logic       ready,
   output logic [1:0] resp
);

   dflt_state_e state_q;
   dflt_state_e state_d;
   logic        start_err;

   assign start_err = hready && unmapped && active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_err) state_d = ERR1;
         ERR1:    state_d = ERR2;
         ERR2:    state_d = start_err ? ERR1 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b1;
      resp  = `HRESP_OKAY;
      unique case (state_q)
         IDLE: ;
         ERR1: begin
            ready = 1'b0;
            resp  = ERR_RESP;
         end
         ERR2: resp = ERR_RESP;
         default: ;
      endcase
   end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: HADDR[31:28] slave decode,
// data-phase response mux and an internal default slave.
module ahb_lite_interconnect
   import ahb_lite_interconnect_pkg::*;
#(
   parameter int         NSLV          = 4,
   parameter logic [1:0] SLV_HRESP_ERR = 2'h1
) (
   input  logic                          HCLK,
   input  logic                          HRESET_N,
   input  logic [`w_HADDR-1:0]           HADDR,
   input  logic [`w_HTRANS-1:0]          HTRANS,
   input  logic                          HWRITE,
   input  logic [`w_HSIZE-1:0]           HSIZE,
   input  logic [`w_HBURST-1:0]          HBURST,
   input  logic [`w_HWDATA-1:0]          HWDATA,
   output logic [`w_HRDATA-1:0]          HRDATA,
   output logic                          HREADY,
   output logic [1:0]                    HRESP,
   output logic [NSLV-1:0]               HSEL_S,
   output logic                          HREADY_S,
   input  logic [NSLV*`w_HRDATA-1:0]     HRDATA_S,
   input  logic [NSLV-1:0]               HREADYOUT_S,
   input  logic [NSLV*2-1:0]             HRESP_S
);

   logic [3:0] slot;
   logic       mapped;
   logic [3:0] tgt;
   logic [3:0] dsel;
   logic       dact;
   logic       dflt_ready;
   logic [1:0] dflt_resp;

   // Write-side signals go to the slaves over the shared bus.
   logic unused_bus;
   assign unused_bus = ^{HWRITE, HSIZE, HBURST, HWDATA,
                         HTRANS[0], HADDR[`w_HADDR-5:0]};

   assign slot   = HADDR[`w_HADDR-1 -: 4];
   assign mapped = int'(slot) < NSLV;
   assign tgt    = mapped ? slot : DSEL_DFLT;

   always_comb begin
      HSEL_S = '0;
      for (int i = 0; i < NSLV; i++) begin
         HSEL_S[i] = (slot == 4'(i));
      end
   end

   always_ff @(posedge HCLK or negedge HRESET_N) begin
      if (!HRESET_N) begin
         dsel <= DSEL_DFLT;
         dact <= 1'b0;
      end else if (HREADY) begin
         dsel <= tgt;
         dact <= trans_active(HTRANS);
      end
   end

   ahb_default_slave #(
      .ERR_RESP (SLV_HRESP_ERR)
   ) u_dflt (
      .clk      (HCLK),
      .rst_n    (HRESET_N),
      .hready   (HREADY),
      .unmapped (!mapped),
      .active   (trans_active(HTRANS)),
      .ready    (dflt_ready),
      .resp     (dflt_resp)
   );

   // The default slave only speaks for an active unmapped data phase.
   always_comb begin
      HRDATA = '0;
      HREADY = dact ? dflt_ready : 1'b1;
      HRESP  = dact ? dflt_resp : `HRESP_OKAY;
      for (int i = 0; i < NSLV; i++) begin
         if (dsel == 4'(i)) begin
            HRDATA = HRDATA_S[i*`w_HRDATA +: `w_HRDATA];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i*2 +: 2];
         end
      end
   end

   assign HREADY_S = HREADY;

endmodule
